// File: rtl/beeb_bus_sequencer_pkg.sv
// Shared types and constants for the BBC Micro 1MHz-bus (page FC) sequencer.
// Latency: n/a. Backpressure: n/a.
package beeb_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_QUALIFY = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_REQ     = 3'd3,
    ST_DRIVE   = 3'd4,
    ST_RELEASE = 3'd5
  } state_t;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;

  // Returned to the bus when the register file never answers a read.
  localparam logic [7:0] READ_TIMEOUT_DATA = 8'hFF;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/beeb_bus_sequencer_sync2.sv
// Pad-input register followed by a two-flop synchroniser for one async strobe.
// Latency: an input change is visible on q after the 3rd rising clk edge. Backpressure: none.
module sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic in_q;
  logic meta_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      in_q   <= RESET_VAL;
      meta_q <= RESET_VAL;
      q      <= RESET_VAL;
    end else begin
      in_q   <= d;
      meta_q <= in_q;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/beeb_bus_sequencer.sv
// Turns a qualified page-FC strobe into one req/ack access on the register file and drives read data back.
// Latency: req 8 edges after strobe fall (FILTER_CYCLES=4). Backpressure: req held until ack or timeout.
module beeb_bus_sequencer
  import beeb_bus_pkg::*;
#(
  parameter int FILTER_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bus_npgfc,
  input  logic              bus_rnw,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic [DATA_W-1:0] bus_din,
  output logic [DATA_W-1:0] bus_dout,
  output logic              bus_doe,
  output logic              reg_req,
  output logic              reg_we,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  input  logic              reg_ack,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              err_timeout
);

  logic npgfc_s;

  state_t            state_q, state_d;
  logic [3:0]        fcnt_q, fcnt_d;
  logic [7:0]        tcnt_q, tcnt_d;
  logic              req_d, we_d, err_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d, dout_d;

  sync2 #(.RESET_VAL(1'b1)) u_sync_npgfc (
    .clk   (clk),
    .reset (reset),
    .d     (bus_npgfc),
    .q     (npgfc_s)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      fcnt_q      <= '0;
      tcnt_q      <= '0;
      reg_req     <= 1'b0;
      reg_we      <= 1'b0;
      reg_addr    <= '0;
      reg_wdata   <= '0;
      bus_dout    <= '0;
      err_timeout <= 1'b0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      tcnt_q      <= tcnt_d;
      reg_req     <= req_d;
      reg_we      <= we_d;
      reg_addr    <= addr_d;
      reg_wdata   <= wdata_d;
      bus_dout    <= dout_d;
      err_timeout <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    tcnt_d  = tcnt_q;
    req_d   = reg_req;
    we_d    = reg_we;
    addr_d  = reg_addr;
    wdata_d = reg_wdata;
    dout_d  = bus_dout;
    err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!npgfc_s) begin
          state_d = ST_QUALIFY;
          fcnt_d  = 4'd1;
        end
      end

      ST_QUALIFY: begin
        if (npgfc_s) begin
          state_d = ST_IDLE;
        end else begin
          fcnt_d = sat_inc4(fcnt_q);
          if (fcnt_d >= 4'(FILTER_CYCLES)) state_d = ST_CAPTURE;
        end
      end

      // Address/data/rnw have been stable for several clocks by now, so a plain sample is safe.
      ST_CAPTURE: begin
        addr_d  = bus_addr;
        we_d    = ~bus_rnw;
        wdata_d = bus_din;
        tcnt_d  = '0;
        req_d   = 1'b1;
        state_d = ST_REQ;
      end

      ST_REQ: begin
        if (reg_ack) begin
          req_d  = 1'b0;
          tcnt_d = '0;
          if (!reg_we) begin
            dout_d  = reg_rdata;
            state_d = ST_DRIVE;
          end else begin
            state_d = ST_RELEASE;
          end
        end else begin
          tcnt_d = sat_inc8(tcnt_q);
          if (tcnt_d >= 8'(TIMEOUT_CYCLES)) begin
            req_d   = 1'b0;
            err_d   = 1'b1;
            dout_d  = DATA_W'(READ_TIMEOUT_DATA);
            state_d = ST_RELEASE;
          end
        end
      end

      ST_DRIVE: begin
        if (npgfc_s) state_d = ST_IDLE;
      end

      ST_RELEASE: begin
        if (npgfc_s) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Gated by the strobe so the bus is released the moment the synchronised strobe goes high.
  assign bus_doe = (state_q == ST_DRIVE) && !npgfc_s;

endmodule

// File: tb/tb_beeb_bus_sequencer.sv
// Directed self-checking bench for beeb_bus_sequencer (FILTER_CYCLES=4, TIMEOUT_CYCLES=64).
module tb_beeb_bus_sequencer;

  localparam int AW = 8;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          bus_npgfc, bus_rnw;
  logic [AW-1:0] bus_addr, reg_addr;
  logic [DW-1:0] bus_din, bus_dout, reg_wdata, reg_rdata;
  logic          bus_doe, reg_req, reg_we, reg_ack, err_timeout;

  int checks   = 0;
  int failures = 0;
  int req_rises = 0;
  int doe_cycles = 0;
  int err_cycles = 0;
  logic req_prev = 1'b0;
  int n, m, base_rises, base_doe, base_err;

  always #5 clk = ~clk;

  beeb_bus_sequencer #(.FILTER_CYCLES(4), .TIMEOUT_CYCLES(64), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .bus_npgfc(bus_npgfc), .bus_rnw(bus_rnw),
    .bus_addr(bus_addr), .bus_din(bus_din), .bus_dout(bus_dout), .bus_doe(bus_doe),
    .reg_req(reg_req), .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_ack(reg_ack), .reg_rdata(reg_rdata), .err_timeout(err_timeout)
  );

  always @(negedge clk) begin
    if (reg_req && !req_prev) req_rises++;
    req_prev = reg_req;
    if (bus_doe) doe_cycles++;
    if (err_timeout) err_cycles++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic wait_req(output int cnt);
    cnt = 0;
    while (reg_req !== 1'b1 && cnt < 40) begin
      step(1);
      cnt++;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req"},   {31'd0, reg_req},     32'd0);
    check({tag, "_we"},    {31'd0, reg_we},      32'd0);
    check({tag, "_addr"},  {24'd0, reg_addr},    32'd0);
    check({tag, "_wdata"}, {24'd0, reg_wdata},   32'd0);
    check({tag, "_dout"},  {24'd0, bus_dout},    32'd0);
    check({tag, "_doe"},   {31'd0, bus_doe},     32'd0);
    check({tag, "_err"},   {31'd0, err_timeout}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; bus_npgfc = 1'b1; bus_rnw = 1'b1; bus_addr = '0; bus_din = '0;
    reg_ack = 1'b0; reg_rdata = '0;
    step(3);
    check_all_zero("rst");
    reset = 1'b0;
    step(2);

    // Write access: req on the 8th edge after the strobe falls, ack two cycles later.
    base_rises = req_rises; base_doe = doe_cycles;
    bus_rnw = 1'b0; bus_addr = 8'h12; bus_din = 8'hA5; bus_npgfc = 1'b0;
    wait_req(n);
    check("wr_req_edge", n, 8);
    check("wr_we", {31'd0, reg_we}, 32'd1);
    check("wr_addr", {24'd0, reg_addr}, 32'h12);
    check("wr_wdata", {24'd0, reg_wdata}, 32'hA5);
    step(1);
    check("wr_req_held", {31'd0, reg_req}, 32'd1);
    reg_ack = 1'b1;
    step(1);
    reg_ack = 1'b0;
    check("wr_req_drop", {31'd0, reg_req}, 32'd0);
    step(10);
    bus_npgfc = 1'b1;
    step(6);
    check("wr_one_req", req_rises - base_rises, 1);
    check("wr_no_doe", doe_cycles - base_doe, 0);

    // Read access: data driven until the 3rd edge after the strobe rises.
    bus_rnw = 1'b1; bus_addr = 8'h40; bus_npgfc = 1'b0;
    wait_req(n);
    check("rd_req_edge", n, 8);
    check("rd_we", {31'd0, reg_we}, 32'd0);
    check("rd_addr", {24'd0, reg_addr}, 32'h40);
    reg_rdata = 8'h3C; reg_ack = 1'b1;
    step(1);
    reg_ack = 1'b0; reg_rdata = 8'h00;
    check("rd_req_drop", {31'd0, reg_req}, 32'd0);
    check("rd_doe", {31'd0, bus_doe}, 32'd1);
    check("rd_dout", {24'd0, bus_dout}, 32'h3C);
    step(4);
    check("rd_dout_hold", {24'd0, bus_dout}, 32'h3C);
    bus_npgfc = 1'b1;
    step(2);
    check("rd_doe_edge2", {31'd0, bus_doe}, 32'd1);
    step(1);
    check("rd_doe_edge3", {31'd0, bus_doe}, 32'd0);
    step(4);

    // Glitch: three low clocks never qualify.
    base_rises = req_rises;
    bus_addr = 8'h99; bus_npgfc = 1'b0;
    step(3);
    bus_npgfc = 1'b1;
    step(15);
    check("gl_no_req", req_rises - base_rises, 0);
    check("gl_idle", {29'd0, dut.state_q}, {29'd0, beeb_bus_pkg::ST_IDLE});

    // Timeout: read with no ack.
    base_doe = doe_cycles; base_err = err_cycles;
    bus_rnw = 1'b1; bus_addr = 8'h55; bus_npgfc = 1'b0;
    wait_req(n);
    check("to_req_edge", n, 8);
    m = 0;
    while (reg_req === 1'b1 && m < 100) begin
      step(1);
      m++;
    end
    check("to_req_cycles", m, 64);
    check("to_err_pulse", {31'd0, err_timeout}, 32'd1);
    check("to_dout_ff", {24'd0, bus_dout}, 32'hFF);
    step(1);
    check("to_err_drop", {31'd0, err_timeout}, 32'd0);
    step(3);
    check("to_err_once", err_cycles - base_err, 1);
    check("to_no_doe", doe_cycles - base_doe, 0);
    bus_npgfc = 1'b1;
    step(8);

    // Reset during REQ, then a stray ack.
    bus_rnw = 1'b0; bus_addr = 8'h77; bus_din = 8'h99; bus_npgfc = 1'b0;
    wait_req(n);
    check("rr_req_up", {31'd0, reg_req}, 32'd1);
    reset = 1'b1; bus_npgfc = 1'b1;
    step(1);
    check_all_zero("rr");
    check("rr_idle", {29'd0, dut.state_q}, {29'd0, beeb_bus_pkg::ST_IDLE});
    reset = 1'b0;
    base_rises = req_rises;
    step(1);
    reg_ack = 1'b1; reg_rdata = 8'h5A;
    step(1);
    reg_ack = 1'b0;
    step(3);
    check_all_zero("rr_ack");
    check("rr_no_req", req_rises - base_rises, 0);

    // Back-to-back strobes, two high clocks between them.
    base_rises = req_rises;
    bus_rnw = 1'b0; bus_addr = 8'h21; bus_din = 8'h11; bus_npgfc = 1'b0;
    wait_req(n);
    check("bb1_req_edge", n, 8);
    check("bb1_addr", {24'd0, reg_addr}, 32'h21);
    check("bb1_wdata", {24'd0, reg_wdata}, 32'h11);
    reg_ack = 1'b1;
    step(1);
    reg_ack = 1'b0;
    step(2);
    bus_npgfc = 1'b1;
    step(2);
    bus_addr = 8'h34; bus_din = 8'h22; bus_npgfc = 1'b0;
    wait_req(n);
    check("bb2_req_edge", n, 8);
    check("bb2_addr", {24'd0, reg_addr}, 32'h34);
    check("bb2_wdata", {24'd0, reg_wdata}, 32'h22);
    reg_ack = 1'b1;
    step(1);
    reg_ack = 1'b0;
    step(3);
    bus_npgfc = 1'b1;
    step(8);
    check("bb_two_reqs", req_rises - base_rises, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
